spi_slave: RTL and testbench

- Byte-oriented SPI responder (slave) that runs entirely in the system clock domain.
- Oversamples externally driven sclk, ss_n and mosi through synchronizers, detects sclk edges, and shifts one byte in and one byte out per 8 sclk cycles.
- Supports all four cpol/cpha modes and back-to-back bytes while ss_n stays low.
- Sits opposite the team's SPI master on a board link, or in loopback testbenches against it.

---
 rtl/spi_slave_if.sv | 22 ++
 rtl/spi_slave.sv | 187 ++++++++++++++++++
 tb/tb_spi_slave.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// spi_slave_if -- SPI pin bundle between a master and the spi_slave responder.
//
// Signals:
//   sclk     serial clock, driven by the master
//   ss_n     active-low slave select, driven by the master
//   mosi     master-out serial data
//   miso     slave-out serial data
//   miso_oe  slave output enable for miso (tri-state control at the pad)
//
// Modports:
//   master   drives sclk/ss_n/mosi, observes miso/miso_oe
//   slave    observes sclk/ss_n/mosi, drives miso/miso_oe
interface spi_slave_if;
   logic sclk;
   logic ss_n;
   logic mosi;
   logic miso;
   logic miso_oe;

   modport master (output sclk, output ss_n, output mosi, input miso, input miso_oe);
   modport slave  (input sclk, input ss_n, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_slave.sv
// spi_slave -- byte-oriented SPI responder running entirely in the clk domain.
//
// sclk, ss_n and mosi are oversampled through SYNC_STAGES-deep synchronizers;
// sclk edges are detected against the cpol idle level and one byte is shifted
// in (si_reg -> dout) and out (so_reg -> miso) per 8 sclk cycles. All four
// cpol/cpha modes and back-to-back bytes under one ss_n low are supported.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   cpol, cpha        SPI mode, static while selected
//   din, wr           transmit byte and its one-cycle capture strobe
//   dout              last completely received byte
//   rx_done_tick      one-cycle pulse when dout updates
//   busy              high while a select is active
//   spi               SPI pins (sclk, ss_n, mosi in; miso, miso_oe out)
//
// Optional build macro SPI_SLAVE_OVERRUN_EN adds:
//   rd_ack            consumer acknowledge for dout
//   rx_valid          unread byte present in dout
//   overrun           sticky: a byte arrived while the previous one was unread
module spi_slave #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cpol,
   input  logic       cpha,
   input  logic [7:0] din,
   input  logic       wr,
   output logic [7:0] dout,
   output logic       rx_done_tick,
   output logic       busy,
`ifdef SPI_SLAVE_OVERRUN_EN
   input  logic       rd_ack,
   output logic       rx_valid,
   output logic       overrun,
`endif
   spi_slave_if.slave spi
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t state, state_next;

   logic [SYNC_STAGES-1:0] sclk_sync, ss_n_sync, mosi_sync, fill;
   logic                   sclk_d;
   logic                   ss_armed;
   logic                   sclk_s, ss_n_s, mosi_s;

   logic [7:0] tx_buf, so_reg, si_reg;
   logic [2:0] n;
   logic       boundary;

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign ss_n_s = ss_n_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   // Synchronizers. fill marks when the ss_n chain holds real pin samples
   // rather than its reset value, so an ss_n already low at reset release
   // never looks like a fresh select: ss_armed needs a genuine high first.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbours, as real hardware does.
      if (reset) begin
         sclk_sync <= {SYNC_STAGES{cpol}};
         ss_n_sync <= '1;
         mosi_sync <= '0;
         fill      <= '0;
         sclk_d    <= cpol;
         ss_armed  <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
         ss_n_sync <= {ss_n_sync[SYNC_STAGES-2:0], spi.ss_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
         fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
         sclk_d    <= sclk_s;
         if (fill[SYNC_STAGES-1] && ss_n_s)
            ss_armed <= 1'b1;
      end
   end

   // Leading edge leaves the idle level, trailing edge returns to it.
   logic leading, trailing, sample_edge, shift_edge;
   assign leading     = (sclk_d == cpol) && (sclk_s != cpol);
   assign trailing    = (sclk_d != cpol) && (sclk_s == cpol);
   assign sample_edge = cpha ? trailing : leading;
   assign shift_edge  = cpha ? leading  : trailing;

   // FSM: state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // FSM: next state. In ACTIVE the ss_n level alone means a rising edge,
   // since ACTIVE is only entered with ss_n low.
   always_comb begin
      // NOTE: default first so every path assigns state_next and no latch
      // is inferred.
      state_next = state;
      case (state)
         IDLE:    if (ss_armed && !ss_n_s) state_next = ACTIVE;
         ACTIVE:  if (ss_n_s)              state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy        = 1'b0;
      spi.miso_oe = 1'b0;
      if (state == ACTIVE) begin
         busy        = 1'b1;
         spi.miso_oe = 1'b1;
      end
   end

   assign spi.miso = so_reg[7];

   // Abort wins over a coincident sample edge: shifting only runs while the
   // synchronized select is still low.
   logic select, active_run, byte_done;
   assign select     = (state == IDLE) && (state_next == ACTIVE);
   assign active_run = (state == ACTIVE) && !ss_n_s;
   assign byte_done  = active_run && sample_edge && (n == 3'd7);

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_buf       <= 8'h00;
         so_reg       <= 8'h00;
         si_reg       <= 8'h00;
         dout         <= 8'h00;
         n            <= 3'd0;
         boundary     <= 1'b0;
         rx_done_tick <= 1'b0;
      end else begin
         rx_done_tick <= byte_done;
         // A load in the same cycle still reads the old tx_buf.
         if (wr)
            tx_buf <= din;
         if (select) begin
            so_reg   <= tx_buf;
            n        <= 3'd0;
            boundary <= cpha;
         end else if (active_run) begin
            if (sample_edge) begin
               si_reg <= {si_reg[6:0], mosi_s};
               if (n == 3'd7) begin
                  dout     <= {si_reg[6:0], mosi_s};
                  n        <= 3'd0;
                  boundary <= 1'b1;
               end else begin
                  n <= n + 3'd1;
               end
            end
            // Sample and shift edges are never the same edge, so the two
            // boundary updates cannot collide.
            if (shift_edge) begin
               if (boundary) begin
                  so_reg   <= tx_buf;
                  boundary <= 1'b0;
               end else begin
                  so_reg <= {so_reg[6:0], 1'b0};
               end
            end
         end
      end
   end

`ifdef SPI_SLAVE_OVERRUN_EN
   // A new byte takes priority over an acknowledge in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_valid <= 1'b0;
         overrun  <= 1'b0;
      end else if (byte_done) begin
         rx_valid <= 1'b1;
         if (rx_valid)
            overrun <= 1'b1;
      end else if (rd_ack) begin
         rx_valid <= 1'b0;
         overrun  <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave -- directed bench for spi_slave.
//
// A bench-side SPI master bit-bangs sclk/ss_n/mosi with a 16-clk sclk period
// and reads miso. Expected received bytes are queued by the master when it
// completes a byte under a valid select; a compare process checks dout on
// every rx_done_tick against that queue, checks that dout holds otherwise,
// and checks busy/miso_oe against the select state once synchronizers settle.
module tb_spi_slave;

   localparam int SYNC = 2;
   localparam int HP   = 8;   // sclk half period in clk cycles

   logic       clk = 1'b0;
   logic       reset;
   logic       cpol, cpha;
   logic [7:0] din;
   logic       wr;
   logic [7:0] dout;
   logic       rx_done_tick;
   logic       busy;
`ifdef SPI_SLAVE_OVERRUN_EN
   logic       rd_ack;
   logic       rx_valid;
   logic       overrun;
`endif

   spi_slave_if spi_bus ();

   spi_slave #(.SYNC_STAGES(SYNC)) dut (
      .clk          (clk),
      .reset        (reset),
      .cpol         (cpol),
      .cpha         (cpha),
      .din          (din),
      .wr           (wr),
      .dout         (dout),
      .rx_done_tick (rx_done_tick),
      .busy         (busy),
`ifdef SPI_SLAVE_OVERRUN_EN
      .rd_ack       (rd_ack),
      .rx_valid     (rx_valid),
      .overrun      (overrun),
`endif
      .spi          (spi_bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state
   logic [7:0] exp_q[$];
   logic [7:0] last_dout = 8'h00;
   logic       sel_ok    = 1'b0;   // current select is one the slave honours
   logic       armed_m   = 1'b0;   // ss_n seen high since reset
   int         tick_cnt  = 0;
   int         settle    = 0;
   logic       prev_ss   = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   // Compare process: one pass per clk, away from the active edge.
   always @(negedge clk) begin
      if (reset) begin
         last_dout = 8'h00;
         exp_q.delete();
         settle = 0;
      end else begin
         if (spi_bus.ss_n != prev_ss) settle = 0;
         else                         settle++;
         if (rx_done_tick) begin
            tick_cnt++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL rx_tick: got unexpected tick dout=%0h expected no tick at %0t", dout, $time);
            end else begin
               last_dout = exp_q.pop_front();
               check("rx_byte", dout, last_dout);
            end
         end else begin
            check("dout_hold", dout, last_dout);
         end
         if (settle > SYNC + 2) begin
            check("busy_vs_select", busy, sel_ok && !spi_bus.ss_n);
            check("oe_vs_select", spi_bus.miso_oe, sel_ok && !spi_bus.ss_n);
         end
      end
      prev_ss = spi_bus.ss_n;
   end

   task automatic do_reset();
      reset = 1'b1;
      cyc(2);
      reset   = 1'b0;
      sel_ok  = 1'b0;
      armed_m = spi_bus.ss_n;
      cyc(1);
   endtask

   task automatic write_tx(input logic [7:0] v);
      din = v;
      wr  = 1'b1;
      cyc(1);
      wr  = 1'b0;
   endtask

   task automatic set_mode(input logic cp, input logic ch);
      cpol = cp;
      cpha = ch;
      spi_bus.sclk = cp;
      cyc(8);
   endtask

   task automatic sel();
      spi_bus.ss_n = 1'b0;
      sel_ok = armed_m;
      cyc(HP);
   endtask

   task automatic desel();
      cyc(HP);
      spi_bus.ss_n = 1'b1;
      armed_m = 1'b1;
      sel_ok  = 1'b0;
   endtask

   task automatic half_wr(input logic do_wr, input logic [7:0] v);
      if (do_wr) begin
         write_tx(v);
         cyc(HP - 1);
      end else begin
         cyc(HP);
      end
   endtask

   // Master side of nbits sclk cycles; optionally pulses wr at bit wr_bit.
   task automatic spi_bits(input logic [7:0] tx, input int nbits, input int wr_bit,
                           input logic [7:0] wr_val, output logic [7:0] rx);
      rx = 8'h00;
      if (!cpha) spi_bus.mosi = tx[7];
      for (int i = 0; i < nbits; i++) begin
         if (!cpha) begin
            half_wr(i == wr_bit, wr_val);
            if (i == 7 && sel_ok) exp_q.push_back(tx);
            spi_bus.sclk = ~cpol;
            rx[7-i] = spi_bus.miso;
            cyc(HP);
            spi_bus.sclk = cpol;
            if (i < 7) spi_bus.mosi = tx[6-i];
         end else begin
            spi_bus.sclk = ~cpol;
            spi_bus.mosi = tx[7-i];
            half_wr(i == wr_bit, wr_val);
            if (i == 7 && sel_ok) exp_q.push_back(tx);
            rx[7-i] = spi_bus.miso;
            spi_bus.sclk = cpol;
            cyc(HP);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] rx, rx2;
      int t0;
      logic [1:0] m;

      reset = 1'b1; cpol = 1'b0; cpha = 1'b0; din = 8'h00; wr = 1'b0;
      spi_bus.sclk = 1'b0; spi_bus.ss_n = 1'b1; spi_bus.mosi = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
      rd_ack = 1'b0;
`endif
      do_reset();
      cyc(10);

      // Reset state
      check("rst_dout", dout, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_oe", spi_bus.miso_oe, 1'b0);
      check("rst_tick", rx_done_tick, 1'b0);
      check("rst_miso", spi_bus.miso, 1'b0);

      // Mode 0 basic byte
      write_tx(8'hA5);
      check("m0_oe_before", spi_bus.miso_oe, 1'b0);
      t0 = tick_cnt;
      sel();
      check("m0_oe_during", spi_bus.miso_oe, 1'b1);
      spi_bits(8'h3C, 8, -1, 8'h00, rx);
      cyc(SYNC + 3);
      check("m0_rx_master", rx, 8'hA5);
      check("m0_dout", dout, 8'h3C);
      check("m0_ticks", tick_cnt - t0, 1);
      desel();
      cyc(SYNC + 3);
      check("m0_oe_after", spi_bus.miso_oe, 1'b0);

      // All four modes
      for (int k = 0; k < 4; k++) begin
         m = 2'(k);
         set_mode(m[1], m[0]);
         write_tx(8'h7E);
         sel();
         if (m[0]) check("cpha1_no_early_msb", spi_bus.miso, 1'b0);
         spi_bits(8'h81, 8, -1, 8'h00, rx);
         cyc(SYNC + 3);
         check("modes_rx_master", rx, 8'h7E);
         check("modes_dout", dout, 8'h81);
         desel();
         cyc(SYNC + 3);
      end

      // Two bytes under one select, tx_buf rewritten during byte 1
      set_mode(1'b0, 1'b0);
      write_tx(8'h11);
      t0 = tick_cnt;
      sel();
      spi_bits(8'hC3, 8, 3, 8'h22, rx);
      spi_bits(8'h96, 8, -1, 8'h00, rx2);
      cyc(SYNC + 3);
      check("b2b_rx1", rx, 8'h11);
      check("b2b_rx2", rx2, 8'h22);
      check("b2b_ticks", tick_cnt - t0, 2);
      check("b2b_dout", dout, 8'h96);
      desel();
      cyc(SYNC + 3);

      // Abort after 5 bits
      t0 = tick_cnt;
      sel();
      spi_bits(8'hF0, 5, -1, 8'h00, rx);
      desel();
      cyc(SYNC + 2);
      check("abort_busy", busy, 1'b0);
      check("abort_oe", spi_bus.miso_oe, 1'b0);
      check("abort_dout", dout, 8'h96);
      check("abort_ticks", tick_cnt - t0, 0);
      cyc(HP);
      sel();
      spi_bits(8'h55, 8, -1, 8'h00, rx);
      cyc(SYNC + 3);
      check("after_abort_dout", dout, 8'h55);
      check("after_abort_rx", rx, 8'h22);
      desel();
      cyc(SYNC + 3);

      // Reset mid-byte with ss_n held low
      sel();
      spi_bits(8'hE7, 3, -1, 8'h00, rx);
      do_reset();
      check("mid_rst_dout", dout, 8'h00);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_oe", spi_bus.miso_oe, 1'b0);
      check("mid_rst_miso", spi_bus.miso, 1'b0);
      check("mid_rst_tick", rx_done_tick, 1'b0);
      t0 = tick_cnt;
      spi_bits(8'h99, 8, -1, 8'h00, rx);
      cyc(SYNC + 3);
      check("no_rx_without_select", tick_cnt - t0, 0);
      check("no_rx_dout", dout, 8'h00);
      check("no_rx_busy", busy, 1'b0);
      desel();
      cyc(SYNC + 3);
      sel();
      spi_bits(8'h5A, 8, -1, 8'h00, rx);
      cyc(SYNC + 3);
      check("post_rst_dout", dout, 8'h5A);
      check("post_rst_rx", rx, 8'h00);
      desel();
      cyc(SYNC + 3);

`ifdef SPI_SLAVE_OVERRUN_EN
      rd_ack = 1'b1; cyc(1); rd_ack = 1'b0; cyc(1);
      check("ack_valid_clr", rx_valid, 1'b0);
      check("ack_ovr_clr", overrun, 1'b0);
      sel();
      spi_bits(8'h01, 8, -1, 8'h00, rx);
      cyc(SYNC + 3);
      check("ovr_valid_1", rx_valid, 1'b1);
      check("ovr_none_yet", overrun, 1'b0);
      spi_bits(8'h02, 8, -1, 8'h00, rx);
      cyc(SYNC + 3);
      desel();
      cyc(SYNC + 3);
      check("ovr_set", overrun, 1'b1);
      check("ovr_dout", dout, 8'h02);
      rd_ack = 1'b1; cyc(1); rd_ack = 1'b0; cyc(1);
      check("ovr_valid_clr", rx_valid, 1'b0);
      check("ovr_clr", overrun, 1'b0);
`endif

      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
